// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Module   : wb_arbiter_pkg
// Purpose  : Shared register-file geometry and writeback entry type.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int REG_NUM    = 32;

    localparam logic [REG_W-1:0] ZERO_WORD    = '0;
    localparam logic             RST_ENABLE   = 1'b0;
    localparam logic             WRITE_ENABLE = 1'b1;

    localparam int WB_LL_DEPTH = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO holding long-latency writeback entries.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_LL_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  wb_entry_t     push_data_i,
    input  logic          pop_i,
    output wb_entry_t     head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges pipeline and long-latency results onto the register-file
//            write port. Define WB_SCOREBOARD_EN to build the RAW scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_LL_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [REG_W-1:0]      pipe_wdata_i,
    input  logic                  ll_valid_i,
    input  logic [REG_ADDR_W-1:0] ll_waddr_i,
    input  logic [REG_W-1:0]      ll_wdata_i,
    output logic                  ll_ready_o,
    output logic                  stall_o,
    input  logic                  ll_issue_i,
    input  logic [REG_ADDR_W-1:0] ll_issue_addr_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic                  hz1_o,
    output logic                  hz2_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [REG_W-1:0]      wdata_o
);

    wb_entry_t                w_head;
    wb_entry_t                w_push_data;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pipe_used;
    logic                     w_push;
    logic                     w_pop;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_unused;

    assign w_pipe_used = pipe_we_i && (pipe_waddr_i != '0);
    // Writes to x0 are dropped at the door so they never occupy a slot.
    assign w_push      = ll_valid_i && !w_full && (ll_waddr_i != '0);
    assign w_pop       = !w_pipe_used && !w_empty;
    assign w_push_data = '{addr: ll_waddr_i, data: ll_wdata_i};

    assign ll_ready_o  = !w_full;
    assign stall_o     = w_full;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            we_o    <= !WRITE_ENABLE;
            waddr_o <= '0;
            wdata_o <= ZERO_WORD;
        end else if (w_pipe_used) begin
            we_o    <= WRITE_ENABLE;
            waddr_o <= pipe_waddr_i;
            wdata_o <= pipe_wdata_i;
        end else if (w_pop) begin
            we_o    <= WRITE_ENABLE;
            waddr_o <= w_head.addr;
            wdata_o <= w_head.data;
        end else begin
            we_o    <= !WRITE_ENABLE;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [REG_NUM-1:0] r_pend;
    logic [REG_NUM-1:0] w_set;
    logic [REG_NUM-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (ll_issue_i && (ll_issue_addr_i != '0)) begin
            w_set[ll_issue_addr_i] = 1'b1;
        end
        if (w_pop) begin
            w_clr[w_head.addr] = 1'b1;
        end
    end

    // Set is applied after clear so a re-issue on the pop edge keeps the bit.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_pend <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_clr) | w_set) & ~REG_NUM'(1);
        end
    end

    assign hz1_o    = r_pend[raddr1_i];
    assign hz2_o    = r_pend[raddr2_i];
    assign w_unused = &{1'b0, w_count};
`else
    assign hz1_o    = 1'b0;
    assign hz2_o    = 1'b0;
    assign w_unused = &{1'b0, w_count, ll_issue_i, ll_issue_addr_i, raddr1_i, raddr2_i};
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Scoreboard bench for wb_arbiter (works with or without scoreboard).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we_i, ll_valid_i, ll_issue_i;
    logic [4:0]  pipe_waddr_i, ll_waddr_i, ll_issue_addr_i, raddr1_i, raddr2_i;
    logic [31:0] pipe_wdata_i, ll_wdata_i;
    logic        ll_ready_o, stall_o, hz1_o, hz2_o, we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        mfifo[$];
    ent_t        exp_q[$];
    logic [31:0] mpend = '0;
    bit          sb_en;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .ll_valid_i(ll_valid_i), .ll_waddr_i(ll_waddr_i), .ll_wdata_i(ll_wdata_i),
        .ll_ready_o(ll_ready_o), .stall_o(stall_o),
        .ll_issue_i(ll_issue_i), .ll_issue_addr_i(ll_issue_addr_i),
        .raddr1_i(raddr1_i), .raddr2_i(raddr2_i), .hz1_o(hz1_o), .hz2_o(hz2_o),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    always #5 clk = ~clk;

    // Reference model: decides each edge's write and pushes it to exp_q.
    always @(posedge clk) begin : p_model
        ent_t        e;
        logic [31:0] clr, set;
        bit          full;
        if (rst) begin
            full = (mfifo.size() == DEPTH);
            clr  = '0;
            set  = '0;
            if (pipe_we_i && pipe_waddr_i != 0) begin
                exp_q.push_back({pipe_waddr_i, pipe_wdata_i});
            end else if (mfifo.size() > 0) begin
                e = mfifo.pop_front();
                exp_q.push_back(e);
                clr[e.a] = 1'b1;
            end
            if (ll_valid_i && !full && ll_waddr_i != 0) mfifo.push_back({ll_waddr_i, ll_wdata_i});
            if (ll_issue_i && ll_issue_addr_i != 0) set[ll_issue_addr_i] = 1'b1;
            mpend = ((mpend & ~clr) | set) & ~32'd1;
        end
    end

    // Scoreboard monitor: compares every edge against the model.
    always @(posedge clk) begin : p_monitor
        ent_t e;
        #1;
        if (rst) begin
            tests++;
            if (we_o) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_write: unexpected write x%0d=%h, expected no write", waddr_o, wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr_o, wdata_o} !== {e.a, e.d}) begin
                        fails++;
                        $display("FAIL sb_write: got x%0d=%h, expected x%0d=%h", waddr_o, wdata_o, e.a, e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL sb_write: no write, expected x%0d=%h", exp_q[0].a, exp_q[0].d);
                exp_q.delete();
            end
            tests++;
            if (ll_ready_o !== (mfifo.size() < DEPTH) || stall_o !== (mfifo.size() == DEPTH)) begin
                fails++;
                $display("FAIL sb_flow: ready=%b stall=%b, expected ready=%b stall=%b",
                         ll_ready_o, stall_o, mfifo.size() < DEPTH, mfifo.size() == DEPTH);
            end
            tests++;
            if (hz1_o !== (sb_en & mpend[raddr1_i]) || hz2_o !== (sb_en & mpend[raddr2_i])) begin
                fails++;
                $display("FAIL sb_hz: hz1=%b hz2=%b, expected %b %b",
                         hz1_o, hz2_o, sb_en & mpend[raddr1_i], sb_en & mpend[raddr2_i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
        ll_valid_i = 0; ll_waddr_i = 0; ll_wdata_i = 0;
        ll_issue_i = 0; ll_issue_addr_i = 0; raddr1_i = 0; raddr2_i = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #3;
        tests++;
        if ({we_o, waddr_o, wdata_o} !== 38'd0) begin
            fails++;
            $display("FAIL reset_out: we=%b waddr=%0d wdata=%h, expected 0/0/0", we_o, waddr_o, wdata_o);
        end
        tests++;
        if ({ll_ready_o, stall_o, hz1_o, hz2_o} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_flags: ready/stall/hz1/hz2=%b, expected 1000",
                     {ll_ready_o, stall_o, hz1_o, hz2_o});
        end
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_pipe_write();
        pipe_we_i = 1; pipe_waddr_i = 5; pipe_wdata_i = 32'h1234;
        step();
        pipe_we_i = 0;
        tests++;
        if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd5, 32'h1234}) begin
            fails++;
            $display("FAIL pipe_write: we=%b x%0d=%h, expected 1 x5=1234", we_o, waddr_o, wdata_o);
        end
        step();
        tests++;
        if ({we_o, waddr_o, wdata_o} !== {1'b0, 5'd5, 32'h1234}) begin
            fails++;
            $display("FAIL pipe_hold: we=%b x%0d=%h, expected 0 x5=1234", we_o, waddr_o, wdata_o);
        end
    endtask

    task automatic test_ll_behind_pipe();
        for (int i = 1; i <= 3; i++) begin
            pipe_we_i = 1; pipe_waddr_i = 5'(i); pipe_wdata_i = 32'h10 + 32'(i);
            ll_valid_i = (i == 1); ll_waddr_i = 7; ll_wdata_i = 32'hAAAA;
            step();
            tests++;
            if (ll_ready_o !== 1'b1 || waddr_o !== 5'(i)) begin
                fails++;
                $display("FAIL ll_behind_pipe: ready=%b waddr=%0d, expected 1 and %0d", ll_ready_o, waddr_o, i);
            end
        end
        pipe_we_i = 0; ll_valid_i = 0;
        step();
        tests++;
        if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd7, 32'hAAAA}) begin
            fails++;
            $display("FAIL ll_drain: we=%b x%0d=%h, expected 1 x7=aaaa", we_o, waddr_o, wdata_o);
        end
    endtask

    task automatic test_back_to_back();
        pipe_we_i = 1; pipe_waddr_i = 10; pipe_wdata_i = 32'hD10;
        ll_valid_i = 1; ll_waddr_i = 11; ll_wdata_i = 32'hB11;
        step();
        pipe_waddr_i = 14; pipe_wdata_i = 32'hD14; ll_waddr_i = 12; ll_wdata_i = 32'hB12;
        step();
        tests++;
        if ({ll_ready_o, stall_o} !== 2'b01) begin
            fails++;
            $display("FAIL full_flags: ready/stall=%b, expected 01", {ll_ready_o, stall_o});
        end
        pipe_we_i = 0; ll_waddr_i = 13; ll_wdata_i = 32'hB13;
        step();
        tests++;
        if ({we_o, waddr_o, ll_ready_o} !== {1'b1, 5'd11, 1'b1}) begin
            fails++;
            $display("FAIL drain_11: we=%b waddr=%0d ready=%b, expected 1 11 1", we_o, waddr_o, ll_ready_o);
        end
        step();
        ll_valid_i = 0;
        tests++;
        if ({we_o, waddr_o} !== {1'b1, 5'd12}) begin
            fails++;
            $display("FAIL drain_12: we=%b waddr=%0d, expected 1 12", we_o, waddr_o);
        end
        step();
        tests++;
        if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd13, 32'hB13}) begin
            fails++;
            $display("FAIL drain_13: we=%b x%0d=%h, expected 1 x13=b13", we_o, waddr_o, wdata_o);
        end
        step();
    endtask

    task automatic test_zero_addr();
        pipe_we_i = 1; pipe_waddr_i = 0; pipe_wdata_i = 32'hFFFF;
        ll_valid_i = 1; ll_waddr_i = 0; ll_wdata_i = 32'hEEEE;
        step();
        clear_inputs();
        tests++;
        if ({we_o, ll_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL zero_addr: we=%b ready=%b, expected 0 1", we_o, ll_ready_o);
        end
        step();
        tests++;
        if (we_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_addr_drain: we=%b, expected 0", we_o);
        end
    endtask

    task automatic test_scoreboard();
        ll_issue_i = 1; ll_issue_addr_i = 9; raddr1_i = 9; raddr2_i = 3;
        step();
        ll_issue_i = 0;
        tests++;
        if ({hz1_o, hz2_o} !== {sb_en, 1'b0}) begin
            fails++;
            $display("FAIL hz_set: hz1/hz2=%b, expected %b0", {hz1_o, hz2_o}, sb_en);
        end
        ll_valid_i = 1; ll_waddr_i = 9; ll_wdata_i = 32'h9999;
        step();
        ll_valid_i = 0;
        ll_issue_i = 1;
        step();
        ll_issue_i = 0;
        tests++;
        if ({we_o, waddr_o, hz1_o} !== {1'b1, 5'd9, sb_en}) begin
            fails++;
            $display("FAIL hz_reissue: we=%b waddr=%0d hz1=%b, expected 1 9 %b", we_o, waddr_o, hz1_o, sb_en);
        end
        ll_valid_i = 1; ll_wdata_i = 32'h9A9A;
        step();
        ll_valid_i = 0;
        step();
        tests++;
        if ({we_o, wdata_o, hz1_o} !== {1'b1, 32'h9A9A, 1'b0}) begin
            fails++;
            $display("FAIL hz_clear: we=%b wdata=%h hz1=%b, expected 1 9a9a 0", we_o, wdata_o, hz1_o);
        end
        raddr1_i = 0; raddr2_i = 0;
    endtask

    task automatic test_reset_mid();
        pipe_we_i = 1; pipe_waddr_i = 1; pipe_wdata_i = 32'h1;
        ll_valid_i = 1; ll_waddr_i = 20; ll_wdata_i = 32'h20;
        ll_issue_i = 1; ll_issue_addr_i = 9; raddr1_i = 9;
        step();
        pipe_waddr_i = 2; ll_waddr_i = 21; ll_issue_i = 0;
        step();
        pipe_we_i = 0; ll_valid_i = 0;
        tests++;
        if (stall_o !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_full: stall=%b, expected 1", stall_o);
        end
        #1;
        rst = 1'b0;
        mfifo.delete(); exp_q.delete(); mpend = '0;
        #1;
        tests++;
        if ({we_o, ll_ready_o, stall_o, hz1_o} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_mid: we/ready/stall/hz1=%b, expected 0100",
                     {we_o, ll_ready_o, stall_o, hz1_o});
        end
        step();
        rst = 1'b1;
        step(); step();
        tests++;
        if (we_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_stale: we=%b waddr=%0d, expected no write", we_o, waddr_o);
        end
        raddr1_i = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            pipe_we_i       = !stall_o && ($urandom_range(0, 1) == 1);
            pipe_waddr_i    = 5'($urandom_range(0, 31));
            pipe_wdata_i    = $urandom;
            ll_valid_i      = ($urandom_range(0, 2) != 0);
            ll_waddr_i      = 5'($urandom_range(0, 31));
            ll_wdata_i      = $urandom;
            ll_issue_i      = ($urandom_range(0, 3) == 0);
            ll_issue_addr_i = 5'($urandom_range(0, 31));
            raddr1_i        = 5'($urandom_range(0, 31));
            raddr2_i        = 5'($urandom_range(0, 31));
            step();
        end
        clear_inputs();
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
`ifdef WB_SCOREBOARD_EN
        sb_en = 1'b1;
`else
        sb_en = 1'b0;
`endif
        test_reset();
        test_pipe_write();
        test_ll_behind_pipe();
        test_back_to_back();
        test_zero_addr();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
